// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// One transaction in flight; data has priority, bounded by a streak limit so fetch cannot starve.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch requester
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_done,
  output logic            i_stall,
  // data requester
  input  logic            d_valid,
  input  logic            d_write,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wstrb,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic            d_stall,
  // downstream memory port
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_write,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  output logic [3:0]      m_wstrb,
  input  logic            m_rvalid,
  input  logic [XLEN-1:0] m_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            dwin_q, dwin_d;
  logic            m_write_q, m_write_d;
  logic [XLEN-1:0] m_addr_q, m_addr_d;
  logic [XLEN-1:0] m_wdata_q, m_wdata_d;
  logic [3:0]      m_wstrb_q, m_wstrb_d;
  logic            i_done_q, i_done_d;
  logic            d_done_q, d_done_d;
  logic [XLEN-1:0] i_rdata_q, i_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            grant_data;

  // Data wins a tie unless it has already taken MAX_D_STREAK grants past a waiting fetch.
  assign grant_data = d_valid & ~(i_valid & (streak_q == STREAK_MAX));

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    dwin_d    = dwin_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_valid | d_valid) begin
          state_d = REQ;
          dwin_d  = grant_data;
          if (grant_data) begin
            m_write_d = d_write;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
            if (!i_valid)
              streak_d = '0;
            else if (streak_q != STREAK_MAX)
              streak_d = streak_q + 1'b1;
          end else begin
            m_write_d = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_wstrb_d = 4'b0000;
            streak_d  = '0;
          end
        end
      end
      REQ: begin
        if (m_ready) state_d = RESP;
      end
      RESP: begin
        if (m_rvalid) begin
          state_d = IDLE;
          if (dwin_q) begin
            d_done_d = 1'b1;
            // store acks carry no data; keep the last load result
            if (!m_write_q) d_rdata_d = m_rdata;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      dwin_q    <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= 4'b0000;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      dwin_q    <= dwin_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_valid = (state_q == REQ);
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_stall = i_valid & ~i_done_q;
  assign d_stall = d_valid & ~d_done_q;

endmodule
